sm_pipe_stage: RTL and testbench



---
 rtl/sm_pipe_stage.sv | 114 +++++++++++
 tb/tb_sm_pipe_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_pipe_stage.sv
// rtl/sm_pipe_stage.sv - DEPTH-stage valid/ready pipeline register with bubble collapsing, flush and occupancy count
// Optional feature macro: SM_PIPE_STAGE_STALL_CNT_EN (output back-pressure cycle counter on stall_cnt).
module sm_pipe_stage #(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                stall_cnt
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             in_xfer;
  logic             out_xfer;

  // Advance chain: a stage may load when it is empty or everything downstream of it moves.
  always_comb begin : adv_chain
    logic a;
    adv = '0;
    a = out_ready || !v_q[DEPTH-1];
    adv[DEPTH-1] = a;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      a = a || !v_q[k];
      adv[k] = a;
    end
  end

  assign in_ready  = adv[0] && !flush;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = v_q[DEPTH-1] && out_ready;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

  // Stage next-state: valids shift on advance, data only follows a valid word so bubbles never overwrite.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (in_xfer) begin
      v_d[0] = 1'b1;
      d_d[0] = in_data;
    end else if (adv[0]) begin
      v_d[0] = 1'b0;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (adv[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          d_d[k] = d_q[k-1];
        end
      end
    end
    if (flush) begin
      v_d = '0;
    end
    count_d = flush ? '0 : (count_q + CW'(in_xfer) - CW'(out_xfer));
  end

  // Stage registers; reset wins over flush and every transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= RST_VAL;
      end
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= count_d;
    end
  end

`ifdef SM_PIPE_STAGE_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where a word is offered but downstream refuses it.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sm_pipe_stage.sv
// tb/tb_sm_pipe_stage.sv - randomized and directed self-checking bench for sm_pipe_stage
module tb_sm_pipe_stage;

  localparam int DEPTH = 2;
  localparam int WIDTH = 32;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        count;
  logic [31:0]       stall_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] d;
    int          pos;
  } ent_t;

  // Model: words in flight oldest first, each with the stage it occupies.
  ent_t        mq[$];
  logic [31:0] m_stall;
  logic [31:0] got[$];
  logic [31:0] expq[$];

  sm_pipe_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(32'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_irdy();
    return !flush && (out_ready || (mq.size() < DEPTH));
  endfunction

  function automatic logic m_ov();
    return (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
  endfunction

  function automatic logic [31:0] m_od();
    return (mq.size() > 0) ? mq[0].d : 32'h0;
  endfunction

  function automatic logic [1:0] m_cnt();
    return 2'(mq.size());
  endfunction

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [31:0] d, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
  endtask

  // One clock edge: record what downstream took, then advance the model.
  task automatic tick();
    logic ix, ov, ox;
    int lim;
    ov = m_ov();
    ix = in_valid && m_irdy();
    ox = ov && out_ready;
    if (out_valid === 1'b1 && out_ready && !rst) got.push_back(out_data);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_stall = 32'h0;
    end else begin
`ifdef SM_PIPE_STAGE_STALL_CNT_EN
      if (ov && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
      if (ox) begin
        expq.push_back(mq[0].d);
        void'(mq.pop_front());
      end
      if (flush) begin
        mq.delete();
      end else begin
        for (int i = 0; i < mq.size(); i++) begin
          lim = DEPTH - 1 - i;
          mq[i].pos = (mq[i].pos + 1 < lim) ? mq[i].pos + 1 : lim;
        end
        if (ix) mq.push_back('{d: in_data, pos: 0});
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 32'h0, 0);
    tick();
    drive(0, 0, 0, 32'h0, 0);
    got.delete();
    expq.delete();
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 32'hDEAD_BEEF, 1);
    tick();
    tick();
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++;
    if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++;
    if (stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
    checks++;
    drive(0, 0, 0, 32'h0, 1);
    tick();
    if (count !== 2'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_no_entry count %0d out_valid %0b exp 0 0", count, out_valid);
    end
    checks++;
  endtask

  task automatic test_streaming();
    logic [31:0] dat [6] = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0};
    logic [5:0]  vld = 6'b000111;
    logic [5:0]  ov_seen;
    int peak;
    do_reset();
    peak = 0;
    ov_seen = '0;
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, vld[c], dat[c], 1);
      tick();
      ov_seen[c] = out_valid;
      if (int'(count) > peak) peak = int'(count);
      if (out_valid !== m_ov() || (m_ov() && out_data !== m_od())) begin
        errors++; $display("FAIL stream_out c%0d got %0b/%h exp %0b/%h", c, out_valid, out_data, m_ov(), m_od());
      end
      checks++;
    end
    if (ov_seen !== 6'b001110) begin errors++; $display("FAIL stream_valid_window got %b exp 001110", ov_seen); end
    checks++;
    if (peak != 2) begin errors++; $display("FAIL stream_peak_count got %0d exp 2", peak); end
    checks++;
    if (got.size() != 3 || got[0] !== 32'h11 || got[1] !== 32'h22 || got[2] !== 32'h33) begin
      errors++; $display("FAIL stream_order got %p exp 11 22 33", got);
    end
    checks++;
  endtask

  task automatic test_back_pressure();
    do_reset();
    drive(0, 0, 1, 32'hA1, 0); tick();
    drive(0, 0, 1, 32'hA2, 0); tick();
    if (count !== 2'd2) begin errors++; $display("FAIL bp_count got %0d exp 2", count); end
    checks++;
    drive(0, 0, 1, 32'hA3, 0);
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got %0b exp 0", in_ready); end
    checks++;
    tick();
    drive(0, 0, 1, 32'hA3, 1);
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release got %0b exp 1", in_ready); end
    checks++;
    tick();
    if (count !== 2'd2) begin errors++; $display("FAIL bp_count_swap got %0d exp 2", count); end
    checks++;
    for (int c = 0; c < 4; c++) begin drive(0, 0, 0, 32'h0, 1); tick(); end
    if (got.size() != 3 || got[0] !== 32'hA1 || got[1] !== 32'hA2 || got[2] !== 32'hA3) begin
      errors++; $display("FAIL bp_order got %p exp A1 A2 A3", got);
    end
    checks++;
  endtask

  task automatic test_bubble_collapse();
    do_reset();
    drive(0, 0, 1, 32'h55, 0); tick();
    drive(0, 0, 0, 32'h0, 0); tick();
    if (out_valid !== 1'b1 || out_data !== 32'h55 || count !== 2'd1) begin
      errors++; $display("FAIL bubble_hold got %0b/%h/%0d exp 1/55/1", out_valid, out_data, count);
    end
    checks++;
    drive(0, 0, 1, 32'h66, 0);
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready got %0b exp 1", in_ready); end
    checks++;
    tick();
    if (count !== 2'd2 || out_data !== 32'h55) begin
      errors++; $display("FAIL bubble_fill got %0d/%h exp 2/55", count, out_data);
    end
    checks++;
  endtask

  task automatic test_flush();
    do_reset();
    drive(0, 0, 1, 32'hB1, 0); tick();
    drive(0, 0, 1, 32'hB2, 0); tick();
    drive(0, 1, 1, 32'hEE, 0);
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0b exp 0", in_ready); end
    checks++;
    tick();
    if (count !== 2'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_clear got %0d/%0b exp 0/0", count, out_valid);
    end
    checks++;
    got.delete();
    drive(0, 0, 1, 32'hC0, 1); tick();
    for (int c = 0; c < 3; c++) begin drive(0, 0, 0, 32'h0, 1); tick(); end
    if (got.size() != 1 || got[0] !== 32'hC0) begin
      errors++; $display("FAIL flush_after got %p exp C0 only", got);
    end
    checks++;
  endtask

  task automatic test_stall_cnt();
    logic [31:0] exp7;
`ifdef SM_PIPE_STAGE_STALL_CNT_EN
    exp7 = 32'd7;
`else
    exp7 = 32'd0;
`endif
    do_reset();
    drive(0, 0, 1, 32'hD1, 0); tick();
    drive(0, 0, 1, 32'hD2, 0); tick();
    for (int c = 0; c < 7; c++) begin drive(0, 0, 0, 32'h0, 0); tick(); end
    if (stall_cnt !== exp7) begin errors++; $display("FAIL stall_hold got %0d exp %0d", stall_cnt, exp7); end
    checks++;
    drive(0, 1, 0, 32'h0, 1); tick();
    if (stall_cnt !== exp7) begin errors++; $display("FAIL stall_after_flush got %0d exp %0d", stall_cnt, exp7); end
    checks++;
    drive(1, 0, 0, 32'h0, 0); tick();
    if (stall_cnt !== 32'h0) begin errors++; $display("FAIL stall_after_rst got %0d exp 0", stall_cnt); end
    checks++;
  endtask

  task automatic test_random();
    logic r, f, iv, ordy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r    = ($urandom_range(0, 99) == 0);
      f    = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      drive(r, f, iv, $urandom, ordy);
      if (in_ready !== m_irdy()) begin errors++; $display("FAIL rnd_in_ready c%0d got %0b exp %0b", c, in_ready, m_irdy()); end
      checks++;
      tick();
      if (out_valid !== m_ov() || (m_ov() && out_data !== m_od())) begin
        errors++; $display("FAIL rnd_out c%0d got %0b/%h exp %0b/%h", c, out_valid, out_data, m_ov(), m_od());
      end
      checks++;
      if (count !== m_cnt()) begin errors++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, count, m_cnt()); end
      checks++;
      if (stall_cnt !== m_stall) begin errors++; $display("FAIL rnd_stall c%0d got %0d exp %0d", c, stall_cnt, m_stall); end
      checks++;
    end
    if (got != expq) begin errors++; $display("FAIL rnd_scoreboard got %0d words exp %0d words", got.size(), expq.size()); end
    checks++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    m_stall = 32'h0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_back_pressure();
    test_bubble_collapse();
    test_flush();
    test_stall_cnt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
